// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter issuing a registered one-hot grant to N_CORES requesters.
// Latency: request sampled in IDLE with Ready low -> grant visible the next cycle.
// Backpressure: no re-arbitration until the bus memory drops Ready after a release.
module bus_arbiter #(
  parameter  int N_CORES        = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  parameter  int CNT_W          = 16,
  localparam int OWN_W          = $clog2(N_CORES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CORES-1:0] Bus_RQ,
  input  logic               Bus_Mem_Ready,
  output logic [N_CORES-1:0] Bus_GRANT,
  output logic [OWN_W-1:0]   Bus_Owner,
  output logic               Bus_Busy,
  output logic               Timeout_Pulse
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GRANTED  = 2'd1,
    S_WAIT_MEM = 2'd2
  } state_t;

  // One extra bit lets the wrapped scan index be computed without overflow.
  localparam logic [OWN_W:0]   N_EXT    = (OWN_W+1)'(N_CORES);
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(N_CORES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);

  state_t               state, state_nxt;
  logic [OWN_W-1:0]     ptr, ptr_nxt;
  logic [CNT_W-1:0]     wd, wd_nxt;
  logic [N_CORES-1:0]   grant_nxt;
  logic [OWN_W-1:0]     owner_nxt;
  logic                 busy_nxt;
  logic                 pulse_nxt;

  logic [OWN_W:0]       idx;
  logic                 found;
  logic [OWN_W-1:0]     winner;

  // Rotating priority scan: first requester at or after the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N_CORES; i++) begin
      idx = {1'b0, ptr} + (OWN_W+1)'(i);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!found && Bus_RQ[idx[OWN_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[OWN_W-1:0];
      end
    end
  end

  // Next-state and next-output decode; registered below so outputs never see inputs directly.
  always_comb begin
    state_nxt = state;
    grant_nxt = Bus_GRANT;
    owner_nxt = Bus_Owner;
    ptr_nxt   = ptr;
    wd_nxt    = wd;
    pulse_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        grant_nxt = '0;
        if (found && !Bus_Mem_Ready) begin
          state_nxt         = S_GRANTED;
          grant_nxt[winner] = 1'b1;
          owner_nxt         = winner;
          ptr_nxt           = (winner == LAST_IDX) ? '0 : winner + OWN_W'(1);
          wd_nxt            = '0;
        end
      end
      S_GRANTED: begin
        wd_nxt = wd + CNT_W'(1);
        // Owner release takes priority over the watchdog, so no pulse on a tie.
        if (!Bus_RQ[Bus_Owner]) begin
          state_nxt = S_WAIT_MEM;
          grant_nxt = '0;
        end else if (WD_EN && (wd == WD_LAST)) begin
          state_nxt = S_WAIT_MEM;
          grant_nxt = '0;
          pulse_nxt = 1'b1;
        end
      end
      S_WAIT_MEM: begin
        grant_nxt = '0;
        if (!Bus_Mem_Ready) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt == S_GRANTED);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Registered outputs, round-robin pointer and watchdog counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Bus_GRANT     <= '0;
      Bus_Owner     <= '0;
      Bus_Busy      <= 1'b0;
      Timeout_Pulse <= 1'b0;
      ptr           <= '0;
      wd            <= '0;
    end else begin
      Bus_GRANT     <= grant_nxt;
      Bus_Owner     <= owner_nxt;
      Bus_Busy      <= busy_nxt;
      Timeout_Pulse <= pulse_nxt;
      ptr           <= ptr_nxt;
      wd            <= wd_nxt;
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus arbiter: the granting end of the per-core RQ/GRANT handshake that each core's arbitration submodule initiates toward the shared data or instruction bus. It samples N request lines, issues exactly one one-hot grant, holds it until the owner drops its request or a watchdog expires, and waits for the bus memory's Ready to return low before re-arbitrating. One instance serves the data bus and one serves the instruction bus.

## Interface
- N_CORES, 4: number of requesting cores (2..16).
- TIMEOUT_CYCLES, 256: maximum cycles a grant may be held; 0 disables the watchdog.
- CNT_W, 16: watchdog counter width; TIMEOUT_CYCLES < 2^CNT_W.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Bus_RQ  in  N_CORES  per-core request; bit i is core i's RQ.
- Bus_Mem_Ready  in  1  bus memory Ready (the value returned to cores as Bus_*Mem_Ready).
- Bus_GRANT  out  N_CORES  one-hot grant, registered.
- Bus_Owner  out  clog2(N_CORES)  index of granted core; valid when Bus_Busy = 1.
- Bus_Busy  out  1  high in GRANTED state.
- Timeout_Pulse  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- States: IDLE, GRANTED, WAIT_MEM. Reset → IDLE.
- Reset values: Bus_GRANT = 0, Bus_Owner = 0, Bus_Busy = 0, Timeout_Pulse = 0, rr pointer = 0, watchdog = 0.
- IDLE: if any Bus_RQ bit high and Bus_Mem_Ready = 0 → winner = first set bit scanning from pointer upward, wrapping modulo N_CORES; GRANTED; Bus_GRANT[winner] = 1; Bus_Owner = winner; pointer = (winner+1) mod N_CORES; watchdog cleared. If Bus_Mem_Ready = 1 → stay IDLE, no grant.
- GRANTED: watchdog increments each cycle. Bus_RQ[Bus_Owner] = 0 → WAIT_MEM, Bus_GRANT cleared. Otherwise, if TIMEOUT_CYCLES ≠ 0 and watchdog = TIMEOUT_CYCLES-1 → WAIT_MEM, Bus_GRANT cleared, Timeout_Pulse = 1 for one cycle. Non-owner RQ changes are ignored.
- WAIT_MEM: Bus_Mem_Ready = 0 → IDLE; else stay. No grant in this state.
- Bus_GRANT always zero or one-hot; never two cores granted, never granted outside GRANTED.
- Owner drop and watchdog expiry in the same cycle: normal release, no Timeout_Pulse.
- Revoked core still holding RQ re-competes normally; pointer has already moved past it, so other pending requesters win first.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Grant latency: RQ high sampled at edge k in IDLE with Ready low → Bus_GRANT high after edge k (visible cycle k+1).
- Release: owner RQ low sampled at edge k → Bus_GRANT low after edge k.
- Re-grant gap: WAIT_MEM with Ready low at edge k+1 → IDLE; next grant after edge k+2. Minimum 2 cycles with grant low between owners.
- Watchdog: grant held exactly TIMEOUT_CYCLES cycles before revoke.
- reset asserted mid-grant: Bus_GRANT, Bus_Busy drop immediately (asynchronous); pointer returns to 0.

## Test plan
- Single request: N_CORES=4, Bus_RQ=0010, Ready=0 → Bus_GRANT=0010, Bus_Owner=1 one cycle later; drop RQ → GRANT=0000 next cycle; IDLE two cycles after drop.
- Round robin: Bus_RQ=1111 held, each owner drops and re-raises RQ after 3 granted cycles → grant order 0,1,2,3,0; never two bits set.
- Memory gating: Bus_RQ=0001 with Ready=1 → no grant while Ready=1; Ready→0 → grant 0001 next cycle. Owner releases while Ready=1 → stays WAIT_MEM until Ready=0.
- Watchdog: TIMEOUT_CYCLES=8, core 2 holds RQ → GRANT=0100 for exactly 8 cycles, Timeout_Pulse high one cycle, core 3 (RQ pending) granted next; TIMEOUT_CYCLES=0 → grant held for 1000 cycles, no pulse.
- Simultaneous release/timeout: owner drops RQ on expiry cycle → GRANT cleared, Timeout_Pulse stays 0.
- Reset mid-grant: assert reset while GRANT=1000 → all outputs 0 without a clock edge; after release, Bus_RQ=1001 → core 0 granted first.
